// File: rtl/uart_pkg.sv
// Shared parity-mode encodings and the mode-to-parity-bit helpers used by the
// parity engine and its entry buffer.
package uart_pkg;

  localparam logic [2:0] PM_NONE  = 3'b000;
  localparam logic [2:0] PM_EVEN  = 3'b001;
  localparam logic [2:0] PM_ODD   = 3'b010;
  localparam logic [2:0] PM_MARK  = 3'b011;
  localparam logic [2:0] PM_SPACE = 3'b100;

  // Level driven on the parity line when no parity is in use.
  localparam logic IDLE_PAR_BIT = 1'b1;

  typedef enum logic [2:0] {
    MODE_NONE  = 3'b000,
    MODE_EVEN  = 3'b001,
    MODE_ODD   = 3'b010,
    MODE_MARK  = 3'b011,
    MODE_SPACE = 3'b100
  } parity_mode_e;

  // Per-word metadata carried alongside the data word in each buffer entry.
  typedef struct packed {
    logic err;
    logic par;
  } par_tag_t;

  // Encodings 101-111 fold onto "none".
  function automatic logic mode_is_none(input logic [2:0] mode);
    logic none;
    none = 1'b1;
    case (mode)
      PM_EVEN, PM_ODD, PM_MARK, PM_SPACE: none = 1'b0;
      default:                            none = 1'b1;
    endcase
    return none;
  endfunction

  // data_xor is the XOR reduction of the data word.
  function automatic logic mode_to_bit(input logic [2:0] mode, input logic data_xor);
    logic pbit;
    pbit = IDLE_PAR_BIT;
    case (mode)
      PM_EVEN:  pbit = data_xor;
      PM_ODD:   pbit = ~data_xor;
      PM_MARK:  pbit = 1'b1;
      PM_SPACE: pbit = 1'b0;
      default:  pbit = IDLE_PAR_BIT;
    endcase
    return pbit;
  endfunction

endpackage

// File: rtl/parity_fifo2.sv
// Two-entry word buffer with a registered ready flag; entries reset to a
// caller-supplied value so the head reads a defined word after reset.
module parity_fifo2
  import uart_pkg::*;
#(
  parameter int          W           = 10,
  parameter logic [W-1:0] RESET_ENTRY = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  output logic         in_ready_o,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         out_valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         ready_q, ready_d;
  logic         do_push, do_pop;

  // Both strobes are re-qualified here so the buffer can never over/underflow.
  always_comb begin
    do_push  = push_i && ready_q;
    do_pop   = pop_i && (count_q != 2'd0);
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
      mem_q[0] <= RESET_ENTRY;
      mem_q[1] <= RESET_ENTRY;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign rd_data_o   = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/parity_engine.sv
// Parity generate/check engine with a two-entry output buffer and error
// reporting. Define PARITY_ERR_CNT_EN to build the saturating error counter.
module parity_engine
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        IN_MODE,
  input  logic              IN_CHK,
  input  logic              IN_PAR_BIT,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_PAR_BIT,
  output logic              OUT_ERR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  input  logic              ERR_CLR,
  output logic              ERR_STICKY,
  output logic [CNT_W-1:0]  ERR_CNT
);

  localparam int ENTRY_W = DATA_W + 2;
  localparam logic [ENTRY_W-1:0] RESET_ENTRY = {1'b0, IDLE_PAR_BIT, {DATA_W{1'b0}}};

  logic               calc_par;
  logic               calc_err;
  logic               accept;
  logic               deliver;
  par_tag_t           wr_tag;
  par_tag_t           rd_tag;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic [1:0]         fill;
  logic               sticky_q, sticky_d;

  // Parity and error are frozen at acceptance so later mode changes cannot
  // reach words already buffered.
  always_comb begin
    calc_par   = mode_to_bit(IN_MODE, ^IN_DATA);
    calc_err   = IN_CHK && !mode_is_none(IN_MODE) && (calc_par != IN_PAR_BIT);
    wr_tag.err = calc_err;
    wr_tag.par = calc_par;
    wr_entry   = {wr_tag, IN_DATA};
  end

  assign accept  = IN_VALID && IN_READY;
  assign deliver = OUT_VALID && OUT_READY;

  parity_fifo2 #(
    .W           (ENTRY_W),
    .RESET_ENTRY (RESET_ENTRY)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (accept),
    .wr_data_i   (wr_entry),
    .in_ready_o  (IN_READY),
    .pop_i       (deliver),
    .rd_data_o   (rd_entry),
    .out_valid_o (OUT_VALID),
    .count_o     (fill)
  );

  always_comb begin
    rd_tag      = rd_entry[ENTRY_W-1:DATA_W];
    OUT_DATA    = rd_entry[DATA_W-1:0];
    OUT_PAR_BIT = rd_tag.par;
    OUT_ERR     = rd_tag.err;
  end

  // A new error wins over a clear in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (accept && calc_err) begin
      sticky_d = 1'b1;
    end else if (ERR_CLR) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ERR_STICKY = sticky_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear with a concurrent error restarts the count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (ERR_CLR) begin
      cnt_d = (accept && calc_err) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (accept && calc_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ERR_CNT = cnt_q;
`else
  assign ERR_CNT = '0;
`endif

  // Occupancy is fully reflected in IN_READY/OUT_VALID; kept for debug probing.
  logic [1:0] dbg_fill;
  assign dbg_fill = fill;

endmodule

// File: tb/tb_parity_engine.sv
// Directed bench for parity_engine: generate/check modes, backpressure,
// counter saturation and clear, mid-operation reset, and a 7-bit instance.
module tb_parity_engine;

`ifdef PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [2:0] M_NONE  = 3'b000;
  localparam logic [2:0] M_EVEN  = 3'b001;
  localparam logic [2:0] M_ODD   = 3'b010;
  localparam logic [2:0] M_MARK  = 3'b011;
  localparam logic [2:0] M_SPACE = 3'b100;

  logic       CLK, RST;
  logic [7:0] IN_DATA;
  logic       IN_VALID, IN_READY;
  logic [2:0] IN_MODE;
  logic       IN_CHK, IN_PAR_BIT;
  logic [7:0] OUT_DATA;
  logic       OUT_PAR_BIT, OUT_ERR, OUT_VALID, OUT_READY;
  logic       ERR_CLR, ERR_STICKY;
  logic [7:0] ERR_CNT;

  logic [6:0] d7_in_data;
  logic       d7_in_valid, d7_in_ready;
  logic [2:0] d7_in_mode;
  logic       d7_in_chk, d7_in_par_bit;
  logic [6:0] d7_out_data;
  logic       d7_out_par_bit, d7_out_err, d7_out_valid, d7_out_ready;
  logic       d7_err_clr, d7_err_sticky;
  logic [7:0] d7_err_cnt;

  int vectors    = 0;
  int miscompares = 0;

  parity_engine #(.DATA_W(8), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_MODE(IN_MODE), .IN_CHK(IN_CHK), .IN_PAR_BIT(IN_PAR_BIT), .OUT_DATA(OUT_DATA),
    .OUT_PAR_BIT(OUT_PAR_BIT), .OUT_ERR(OUT_ERR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ERR_CLR(ERR_CLR), .ERR_STICKY(ERR_STICKY), .ERR_CNT(ERR_CNT)
  );

  parity_engine #(.DATA_W(7), .CNT_W(8)) dut7 (
    .CLK(CLK), .RST(RST), .IN_DATA(d7_in_data), .IN_VALID(d7_in_valid), .IN_READY(d7_in_ready),
    .IN_MODE(d7_in_mode), .IN_CHK(d7_in_chk), .IN_PAR_BIT(d7_in_par_bit), .OUT_DATA(d7_out_data),
    .OUT_PAR_BIT(d7_out_par_bit), .OUT_ERR(d7_out_err), .OUT_VALID(d7_out_valid),
    .OUT_READY(d7_out_ready), .ERR_CLR(d7_err_clr), .ERR_STICKY(d7_err_sticky), .ERR_CNT(d7_err_cnt)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    int sat;
    sat = (n > 255) ? 255 : n;
    return CNT_EN ? 32'(sat) : 32'd0;
  endfunction

  // Driver: present one word for exactly one clock (engine must be ready).
  task automatic send(input logic [7:0] data, input logic [2:0] mode,
                      input logic chk, input logic par, input logic clr);
    IN_DATA    = data;
    IN_MODE    = mode;
    IN_CHK     = chk;
    IN_PAR_BIT = par;
    ERR_CLR    = clr;
    IN_VALID   = 1'b1;
    tick();
    IN_VALID   = 1'b0;
    ERR_CLR    = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] data,
                            input logic par, input logic err);
    check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, "_data"},  32'(OUT_DATA), 32'(data));
    check({tag, "_par"},   32'(OUT_PAR_BIT), 32'(par));
    check({tag, "_err"},   32'(OUT_ERR), 32'(err));
  endtask

  initial begin
    RST = 1'b1;
    IN_DATA = '0; IN_VALID = 1'b0; IN_MODE = M_NONE; IN_CHK = 1'b0; IN_PAR_BIT = 1'b0;
    OUT_READY = 1'b1; ERR_CLR = 1'b0;
    d7_in_data = '0; d7_in_valid = 1'b0; d7_in_mode = M_NONE; d7_in_chk = 1'b0;
    d7_in_par_bit = 1'b0; d7_out_ready = 1'b1; d7_err_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    check("rst_out_par", 32'(OUT_PAR_BIT), 32'd1);
    check("rst_out_err", 32'(OUT_ERR), 32'd0);
    check("rst_out_data", 32'(OUT_DATA), 32'd0);
    check("rst_sticky", 32'(ERR_STICKY), 32'd0);
    check("rst_cnt", 32'(ERR_CNT), 32'd0);

    // Generate mode on 8'hA5 (four ones)
    send(8'hA5, M_EVEN, 1'b0, 1'b0, 1'b0);  check_head("gen_even", 8'hA5, 1'b0, 1'b0);
    send(8'hA5, M_ODD, 1'b0, 1'b0, 1'b0);   check_head("gen_odd", 8'hA5, 1'b1, 1'b0);
    send(8'hA5, M_MARK, 1'b0, 1'b0, 1'b0);  check_head("gen_mark", 8'hA5, 1'b1, 1'b0);
    send(8'hA5, M_SPACE, 1'b0, 1'b1, 1'b0); check_head("gen_space", 8'hA5, 1'b0, 1'b0);
    send(8'hA5, M_NONE, 1'b0, 1'b0, 1'b0);  check_head("gen_none", 8'hA5, 1'b1, 1'b0);
    send(8'h3C, 3'b111, 1'b0, 1'b0, 1'b0);  check_head("gen_mode7", 8'h3C, 1'b1, 1'b0);
    check("gen_sticky", 32'(ERR_STICKY), 32'd0);

    // Check mode
    send(8'h01, M_ODD, 1'b1, 1'b1, 1'b0);   check_head("chk_odd_bad", 8'h01, 1'b0, 1'b1);
    check("chk_sticky_set", 32'(ERR_STICKY), 32'd1);
    check("chk_cnt1", 32'(ERR_CNT), exp_cnt(1));
    send(8'h01, M_ODD, 1'b1, 1'b0, 1'b0);   check_head("chk_odd_good", 8'h01, 1'b0, 1'b0);
    check("chk_cnt_hold", 32'(ERR_CNT), exp_cnt(1));
    send(8'hA5, M_NONE, 1'b1, 1'b0, 1'b0);  check_head("chk_none", 8'hA5, 1'b1, 1'b0);
    send(8'hA5, M_EVEN, 1'b1, 1'b1, 1'b0);  check_head("chk_even_bad", 8'hA5, 1'b0, 1'b1);
    check("chk_cnt2", 32'(ERR_CNT), exp_cnt(2));

    // Clear alone, then clear with a concurrent error
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("clr_sticky", 32'(ERR_STICKY), 32'd0);
    check("clr_cnt", 32'(ERR_CNT), 32'd0);
    check("clr_drained", 32'(OUT_VALID), 32'd0);
    send(8'h5A, M_SPACE, 1'b1, 1'b1, 1'b1); check_head("clr_err", 8'h5A, 1'b0, 1'b1);
    check("clr_err_sticky", 32'(ERR_STICKY), 32'd1);
    check("clr_err_cnt", 32'(ERR_CNT), exp_cnt(1));
    tick();
    check("drain_empty", 32'(OUT_VALID), 32'd0);

    // Backpressure: three words back-to-back with the output stalled
    OUT_READY = 1'b0;
    IN_MODE = M_EVEN; IN_CHK = 1'b0; IN_VALID = 1'b1;
    IN_DATA = 8'h13;
    tick();
    check("bp_ready1", 32'(IN_READY), 32'd1);
    IN_DATA = 8'h22;
    tick();
    check("bp_full", 32'(IN_READY), 32'd0);
    check("bp_head1", 32'(OUT_DATA), 32'h13);
    IN_DATA = 8'h37;
    tick();
    check("bp_held", 32'(IN_READY), 32'd0);
    check_head("bp_stall", 8'h13, 1'b1, 1'b0);
    OUT_READY = 1'b1;
    tick();
    check_head("bp_word2", 8'h22, 1'b0, 1'b0);
    check("bp_ready_again", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    check_head("bp_word3", 8'h37, 1'b1, 1'b0);
    tick();
    check("bp_empty", 32'(OUT_VALID), 32'd0);

    // Reset with two words buffered
    OUT_READY = 1'b0;
    send(8'h81, M_EVEN, 1'b1, 1'b1, 1'b0);
    send(8'h03, M_EVEN, 1'b1, 1'b1, 1'b0);
    check("pre_rst_full", 32'(IN_READY), 32'd0);
    check("pre_rst_cnt", 32'(ERR_CNT), exp_cnt(3));
    RST = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1; ERR_CLR = 1'b0;
    tick();
    RST = 1'b0; IN_VALID = 1'b0;
    check("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    check("mid_rst_ready", 32'(IN_READY), 32'd1);
    check("mid_rst_cnt", 32'(ERR_CNT), 32'd0);
    check("mid_rst_sticky", 32'(ERR_STICKY), 32'd0);
    check("mid_rst_par", 32'(OUT_PAR_BIT), 32'd1);
    check("mid_rst_data", 32'(OUT_DATA), 32'd0);

    // Counter saturation, then clear with a concurrent error
    IN_DATA = 8'h01; IN_MODE = M_ODD; IN_CHK = 1'b1; IN_PAR_BIT = 1'b1; IN_VALID = 1'b1;
    repeat (255) tick();
    check("sat_255", 32'(ERR_CNT), exp_cnt(255));
    tick();
    check("sat_hold", 32'(ERR_CNT), exp_cnt(256));
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0; IN_VALID = 1'b0;
    check("sat_clr_err_cnt", 32'(ERR_CNT), exp_cnt(1));
    check("sat_clr_err_sticky", 32'(ERR_STICKY), 32'd1);
    tick();

    // 7-bit data width instance
    d7_in_data = 7'h7F; d7_in_mode = M_EVEN; d7_in_chk = 1'b0; d7_in_valid = 1'b1;
    tick();
    d7_in_valid = 1'b0;
    check("w7_valid", 32'(d7_out_valid), 32'd1);
    check("w7_data", 32'(d7_out_data), 32'h7F);
    check("w7_even", 32'(d7_out_par_bit), 32'd1);
    check("w7_ready", 32'(d7_in_ready), 32'd1);
    d7_in_mode = M_ODD; d7_in_chk = 1'b1; d7_in_par_bit = 1'b1; d7_in_valid = 1'b1;
    tick();
    d7_in_valid = 1'b0;
    check("w7_odd", 32'(d7_out_par_bit), 32'd0);
    check("w7_err", 32'(d7_out_err), 32'd1);
    check("w7_sticky", 32'(d7_err_sticky), 32'd1);
    check("w7_cnt", 32'(d7_err_cnt), exp_cnt(1));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_engine.md
PARITY_ENGINE -- requirements
Module: parity_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data word width; legal range 5..9.
REQ-002 SHALL have parameter CNT_W, default 8, meaning parity-error counter width.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port IN_DATA  input  DATA_W  data word to protect or check.
REQ-006 SHALL have port IN_VALID  input  1  IN_DATA/IN_MODE/IN_CHK/IN_PAR_BIT valid.
REQ-007 SHALL have port IN_READY  output  1  engine can accept a word (registered).
REQ-008 SHALL have port IN_MODE  input  3  parity mode: 000 none, 001 even, 010 odd, 011 mark, 100 space; 101-111 treated as none.
REQ-009 SHALL have port IN_CHK  input  1  0 = generate, 1 = check against IN_PAR_BIT.
REQ-010 SHALL have port IN_PAR_BIT  input  1  received parity bit; used only when IN_CHK=1.
REQ-011 SHALL have port OUT_DATA  output  DATA_W  data word passed through unchanged.
REQ-012 SHALL have port OUT_PAR_BIT  output  1  computed parity bit.
REQ-013 SHALL have port OUT_ERR  output  1  parity mismatch for this word (check mode only).
REQ-014 SHALL have port OUT_VALID  output  1  output word valid.
REQ-015 SHALL have port OUT_READY  input  1  downstream accepts the output word.
REQ-016 SHALL have port ERR_CLR  input  1  clears ERR_STICKY and ERR_CNT.
REQ-017 SHALL have port ERR_STICKY  output  1  set on any accepted word with a parity error.
REQ-018 SHALL have port ERR_CNT  output  CNT_W  saturating count of erroneous accepted words.

Function
REQ-019 SHALL accept a word when IN_VALID && IN_READY; SHALL deliver it when OUT_VALID && OUT_READY.
REQ-020 SHALL buffer words in a 2-entry FIFO; IN_READY = occupancy < 2; OUT_VALID = occupancy > 0.
REQ-021 SHALL present an accepted word on the output side one cycle after acceptance at the earliest; order preserved.
REQ-022 SHALL keep occupancy unchanged on simultaneous accept and deliver; no accept when full, no deliver when empty.
REQ-023 SHALL compute the parity bit at acceptance: even = XOR of IN_DATA; odd = XNOR; mark = 1; space = 0; none = 1 (idle level).
REQ-024 SHALL compute the error at acceptance: IN_CHK=1 and mode not none and computed bit != IN_PAR_BIT; else 0.
REQ-025 SHALL store mode-derived parity bit and error flag with each FIFO entry; later changes to IN_MODE do not alter stored entries.
REQ-026 SHALL set ERR_STICKY the cycle after an accepted erroneous word; set wins over ERR_CLR in the same cycle.
REQ-027 SHALL increment ERR_CNT by 1 per accepted erroneous word, saturating at all-ones; simultaneous ERR_CLR and error loads 1.
REQ-028 SHALL drive OUT_DATA/OUT_PAR_BIT/OUT_ERR from the FIFO head; their value is don't-care when OUT_VALID=0.

Reset
REQ-029 SHALL on RST: occupancy 0, OUT_VALID 0, IN_READY 1 (from the cycle after RST), OUT_PAR_BIT 1, OUT_ERR 0, OUT_DATA 0, ERR_STICKY 0, ERR_CNT 0.
REQ-030 SHALL discard buffered words when RST is asserted mid-operation; RST overrides all other inputs.

Configuration
REQ-031 SHALL, with macro PARITY_ERR_CNT_EN defined, implement ERR_CNT as in REQ-027.
REQ-032 SHALL, without PARITY_ERR_CNT_EN, tie ERR_CNT to 0 and remove its register; ERR_STICKY remains.

Structure
REQ-033 SHALL place the parity-mode encoding constants and the mode-to-bit function in shared package uart_pkg.
REQ-034 SHALL implement the 2-entry buffer as sub-module parity_fifo2 (entry = DATA_W+2 bits).

Verification
REQ-035 Generate even, IN_DATA=8'hA5 -> OUT_PAR_BIT=0 one cycle later; odd, 8'hA5 -> 1; mark -> 1; space -> 0; none -> 1.
REQ-036 Check odd, IN_DATA=8'h01, IN_PAR_BIT=1 -> OUT_ERR=1, ERR_STICKY=1, ERR_CNT=1; IN_PAR_BIT=0 -> OUT_ERR=0.
REQ-037 OUT_READY=0, push 3 words back-to-back -> IN_READY low after 2nd accept; 3rd held; release -> words in order.
REQ-038 ERR_CNT at 8'hFF plus another error -> stays 8'hFF; ERR_CLR with concurrent error -> ERR_CNT=1, ERR_STICKY=1.
REQ-039 RST asserted with 2 words buffered -> next cycle OUT_VALID=0, IN_READY=1, ERR_CNT=0.
REQ-040 DATA_W=7, even, IN_DATA=7'h7F -> OUT_PAR_BIT=1; without PARITY_ERR_CNT_EN, errors -> ERR_CNT stays 0.
